// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder: store size codes, the FSM
// encoding and byte-lane helpers used by the responder datapath.
package data_mem_pkg;

  localparam logic [2:0] SZ_NONE = 3'b000;
  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b010;
  localparam logic [2:0] SZ_WORD = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << addr_lo;
      SZ_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic size_legal(input logic [2:0] size);
    return size inside {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD};
  endfunction

  // Store data arrives right-justified; copy it into every lane it may target.
  function automatic logic [31:0] lane_data(input logic [2:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: lane_data = {4{data[7:0]}};
      SZ_HALF: lane_data = {2{data[15:0]}};
      default: lane_data = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-organised storage with a per-byte-lane write mask and a registered
// (read-before-write) read port.
module mem_word_array #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic             clk,
  input  logic             i_rd_en,
  input  logic [3:0]       i_wr_mask,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [WIDTH-1:0] r_rd_data;

  // NOTE: no reset on the storage or its read register; contents must survive rst and a RAM cannot clear itself.
  always_ff @(posedge clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_addr];
    for (int l = 0; l < 4; l++) begin
      if (i_wr_mask[l]) r_mem[i_addr][8*l +: 8] <= i_wr_data[8*l +: 8];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, committed on the edge that
// enters RESP after WAIT_CYCLES wait states, response held until resp_ready.
import data_mem_pkg::*;

module data_mem_responder #(
  parameter int WORD_LENGTH = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WORD_LENGTH-1:0] address,
  input  logic [WORD_LENGTH-1:0] write_data,
  input  logic [2:0]             write_enable,
  input  logic                   read_enable,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WORD_LENGTH-1:0] data_out,
  output logic                   resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int IW = WORD_LENGTH - 2;

  state_t                 r_state, w_next_state;
  logic [3:0]             r_cnt, w_next_cnt;
  logic [WORD_LENGTH-1:0] r_addr, r_wdata;
  logic [2:0]             r_we;
  logic                   r_re;

  logic                   w_idle, w_accept, w_enter_resp, w_err;
  logic [WORD_LENGTH-1:0] w_addr, w_wdata, w_lanes, w_rd_data, w_merged;
  logic [2:0]             w_we;
  logic                   w_re;
  logic [IW-1:0]          w_index;
  logic [3:0]             w_lane_sel, w_wr_mask;

  assign w_idle = (r_state == IDLE);

  // In IDLE the request is still on the inputs; with no wait states it commits on the accept edge.
  assign w_addr  = w_idle ? address      : r_addr;
  assign w_wdata = w_idle ? write_data   : r_wdata;
  assign w_we    = w_idle ? write_enable : r_we;
  assign w_re    = w_idle ? read_enable  : r_re;
  assign w_index = w_addr[WORD_LENGTH-1:2];

  assign w_accept = w_idle && req_valid && (read_enable || (write_enable != SZ_NONE));

  assign w_err = (w_re && (w_we != SZ_NONE))
              || !size_legal(w_we)
              || ((w_we == SZ_HALF) && w_addr[0])
              || ((w_we == SZ_WORD) && (w_addr[1:0] != 2'b00))
              || (w_index >= IW'(DEPTH_WORDS));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_enter_resp = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_next_state = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next_state = WAIT;
            w_next_cnt   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= SZ_NONE;
      r_re    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_addr  <= address;
        r_wdata <= write_data;
        r_we    <= write_enable;
        r_re    <= read_enable;
      end
    end
  end

  assign w_lane_sel = lane_mask(w_we, w_addr[1:0]);
  assign w_lanes    = lane_data(w_we, w_wdata);
  assign w_wr_mask  = (w_enter_resp && !w_err) ? w_lane_sel : 4'b0000;

  mem_word_array #(
    .WIDTH      (WORD_LENGTH),
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem (
    .clk      (clk),
    .i_rd_en  (w_enter_resp),
    .i_wr_mask(w_wr_mask),
    .i_addr   (w_index[AW-1:0]),
    .i_wr_data(w_lanes),
    .o_rd_data(w_rd_data)
  );

  // The read port returns the pre-store word; overlay the stored lanes to report the updated word.
  always_comb begin
    w_merged = w_rd_data;
    for (int l = 0; l < 4; l++) begin
      if (w_lane_sel[l]) w_merged[8*l +: 8] = w_lanes[8*l +: 8];
    end
  end

  assign req_ready  = w_idle;
  assign resp_valid = (r_state == RESP);
  assign resp_err   = resp_valid && w_err;
  assign data_out   = (resp_valid && !w_err) ? w_merged : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances (2, 0 and 15 wait
// states) share the request bus; a negedge monitor checks every accepted response.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [2:0]  write_enable = SZ_NONE;
  logic        read_enable = 1'b0;
  logic        resp_ready = 1'b1;

  logic        rv   [3] = '{default: 1'b0};
  logic        rr   [3];
  logic        vld  [3];
  logic        rerr [3];
  logic [31:0] dout [3];

  int          lat_exp [3] = '{3, 1, 16};
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.WORD_LENGTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr[0]), .address(address),
    .write_data(write_data), .write_enable(write_enable), .read_enable(read_enable),
    .resp_valid(vld[0]), .resp_ready(resp_ready), .data_out(dout[0]), .resp_err(rerr[0]));

  data_mem_responder #(.WORD_LENGTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr[1]), .address(address),
    .write_data(write_data), .write_enable(write_enable), .read_enable(read_enable),
    .resp_valid(vld[1]), .resp_ready(resp_ready), .data_out(dout[1]), .resp_err(rerr[1]));

  data_mem_responder #(.WORD_LENGTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(15)) u_dut_w15 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rr[2]), .address(address),
    .write_data(write_data), .write_enable(write_enable), .read_enable(read_enable),
    .resp_valid(vld[2]), .resp_ready(resp_ready), .data_out(dout[2]), .resp_err(rerr[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (vld[k] && resp_ready) begin
        check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_data", dout[k], e.data);
          check("resp_err", 32'(rerr[k]), 32'(e.err));
        end
      end
    end
  end

  task automatic start(input int k, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] we, input logic re,
                       input logic [31:0] ed, input logic ee);
    int n;
    n = 0;
    exp_q.push_back(exp_t'({ee, ed}));
    address = a; write_data = d; write_enable = we; read_enable = re;
    rv[k] = 1'b1;
    @(negedge clk);
    while (!rr[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", 32'(rr[k]), 32'd1);
    t_acc = cyc;
    @(posedge clk);
    #1 rv[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (!vld[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(cyc - t_acc), 32'(lat_exp[k]));
    check("req_ready_in_resp", 32'(rr[k]), 32'd0);
  endtask

  task automatic finish_resp(input int k);
    int n;
    n = 0;
    while (!(vld[k] && resp_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input int k, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] we, input logic re,
                      input logic [31:0] ed, input logic ee);
    start(k, a, d, we, re, ed, ee);
    wait_valid(k);
    finish_resp(k);
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_req_ready", 32'(rr[k]), 32'd1);
    check("rst_resp_valid", 32'(vld[k]), 32'd0);
    check("rst_data_out", dout[k], 32'd0);
    check("rst_resp_err", 32'(rerr[k]), 32'd0);
  endtask

  task automatic noop(input int k);
    address = 32'h0; write_data = 32'hFFFF_FFFF; write_enable = SZ_NONE; read_enable = 1'b0;
    rv[k] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("noop_req_ready", 32'(rr[k]), 32'd1);
      check("noop_resp_valid", 32'(vld[k]), 32'd0);
    end
    @(posedge clk);
    #1 rv[k] = 1'b0;
  endtask

  initial begin
    #3;
    for (int k = 0; k < 3; k++) check_reset_outputs(k);
    @(posedge clk);
    #1 rst = 1'b1;

    // Word/byte/half stores and loads on the 2-wait-state instance.
    xact(0, 32'h10,   32'hDEADBEEF, SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b0);
    xact(0, 32'h10,   32'h0,        SZ_NONE, 1'b1, 32'hDEADBEEF, 1'b0);
    xact(0, 32'h11,   32'h000000AA, SZ_BYTE, 1'b0, 32'hDEADAAEF, 1'b0);
    xact(0, 32'h12,   32'h00001234, SZ_HALF, 1'b0, 32'h1234AAEF, 1'b0);
    xact(0, 32'h10,   32'h0,        SZ_NONE, 1'b1, 32'h1234AAEF, 1'b0);
    xact(0, 32'h13,   32'h0000FFFF, SZ_HALF, 1'b0, 32'h0,        1'b1);
    xact(0, 32'h10,   32'h0,        SZ_NONE, 1'b1, 32'h1234AAEF, 1'b0);
    xact(0, 32'h16,   32'h0,        SZ_WORD, 1'b0, 32'h0,        1'b1);
    xact(0, 32'h13,   32'hFFFFFF77, SZ_BYTE, 1'b0, 32'h7734AAEF, 1'b0);
    xact(0, 32'h13,   32'h0,        SZ_NONE, 1'b1, 32'h7734AAEF, 1'b0);
    xact(0, 32'hFFC,  32'hCAFEF00D, SZ_WORD, 1'b0, 32'hCAFEF00D, 1'b0);
    xact(0, 32'hFFE,  32'hFFFFBEEF, SZ_HALF, 1'b0, 32'hBEEFF00D, 1'b0);
    xact(0, 32'h1000, 32'h0,        SZ_NONE, 1'b1, 32'h0,        1'b1);
    xact(0, 32'h1000, 32'h12345678, SZ_WORD, 1'b0, 32'h0,        1'b1);
    xact(0, 32'h10,   32'h11111111, SZ_WORD, 1'b1, 32'h0,        1'b1);
    xact(0, 32'h10,   32'h22222222, 3'b011,  1'b0, 32'h0,        1'b1);
    xact(0, 32'h10,   32'h33333333, 3'b111,  1'b0, 32'h0,        1'b1);
    xact(0, 32'hFFC,  32'h0,        SZ_NONE, 1'b1, 32'hBEEFF00D, 1'b0);

    // Backpressure: response must hold while resp_ready is low.
    resp_ready = 1'b0;
    start(0, 32'h10, 32'h0, SZ_NONE, 1'b1, 32'h7734AAEF, 1'b0);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_valid", 32'(vld[0]), 32'd1);
      check("bp_data_out", dout[0], 32'h7734AAEF);
      check("bp_req_ready", 32'(rr[0]), 32'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("req_ready_after_release", 32'(rr[0]), 32'd1);
    @(posedge clk);
    #1;

    // Reset during WAIT drops the in-flight store.
    xact(0, 32'h20, 32'h00000000, SZ_WORD, 1'b0, 32'h00000000, 1'b0);
    start(0, 32'h20, 32'h00000055, SZ_WORD, 1'b0, 32'h00000055, 1'b0);
    @(negedge clk);
    check("wait_req_ready", 32'(rr[0]), 32'd0);
    #2 rst = 1'b0;
    #1 check_reset_outputs(0);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1 rst = 1'b1;
    xact(0, 32'h20, 32'h0, SZ_NONE, 1'b1, 32'h00000000, 1'b0);

    // Zero-wait-state instance.
    xact(1, 32'h0, 32'h11223344, SZ_WORD, 1'b0, 32'h11223344, 1'b0);
    xact(1, 32'h3, 32'h00000099, SZ_BYTE, 1'b0, 32'h99223344, 1'b0);
    xact(1, 32'h0, 32'h0,        SZ_NONE, 1'b1, 32'h99223344, 1'b0);
    noop(1);

    // Fifteen-wait-state instance.
    xact(2, 32'h4, 32'hA5A5A5A5, SZ_WORD, 1'b0, 32'hA5A5A5A5, 1'b0);
    xact(2, 32'h4, 32'h0,        SZ_NONE, 1'b1, 32'hA5A5A5A5, 1'b0);
    noop(2);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's data-memory port: accepts load/store requests over a valid/ready handshake, applies byte/half/word stores into word-organised storage and returns read data after a programmable wait-state latency.
- Sits between the core's load/store path and on-chip data RAM.
- Replaces the zero-latency memory model so the multi-cycle core can be exercised against realistic memory timing.

Parameters:
- WORD_LENGTH, 32, data and address width.
- DEPTH_WORDS, 1024, number of 32-bit words stored; addressable range is 0 to 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2, idle cycles between request acceptance and response (0 to 15).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- address  input  WORD_LENGTH  byte address.
- write_data  input  WORD_LENGTH  store data, right-justified (byte in [7:0], half in [15:0]).
- write_enable  input  3  store size: 000 none, 001 byte, 010 half, 100 word; any other value is an error.
- read_enable  input  1  load request.
- resp_valid  output  1  response present, held until resp_ready.
- resp_ready  input  1  requester accepts response.
- data_out  output  WORD_LENGTH  full aligned word containing the address; sign/zero extension is done downstream.
- resp_err  output  1  request was rejected; qualified by resp_valid.

Behaviour:
- Reset, asynchronous, active when rst=0:
  - State goes to IDLE; req_ready=1, resp_valid=0, data_out=0, resp_err=0; wait counter=0.
  - Storage contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. A request is accepted when req_valid=1 and it is a load or a store. Accepting latches address, write_data, write_enable and read_enable.
    - WAIT_CYCLES=0: go to RESP.
    - WAIT_CYCLES>0: go to WAIT with counter=WAIT_CYCLES-1.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0 go to RESP.
  - RESP: resp_valid=1 and data_out/resp_err held stable. On resp_valid&&resp_ready go to IDLE, so req_ready returns the following cycle.
- No-op: req_valid=1 with write_enable=000 and read_enable=0 is ignored. No state change, req_ready stays 1.
- Error conditions (resp_err=1, storage unchanged, data_out=0):
  - read_enable=1 and write_enable!=000 at the same time.
  - write_enable is an illegal code.
  - Misalignment: a half access with address[0]=1, or a word access with address[1:0]!=00. Loads are always word-aligned reads (address[1:0] ignored), so misalignment applies only to stores.
  - Word index address[WORD_LENGTH-1:2] >= DEPTH_WORDS.
- Store commit:
  - The write to storage happens on the clock edge entering RESP, not at acceptance.
  - Byte lanes: byte store writes lane address[1:0] with write_data[7:0]; half store writes lanes {address[1],0} and {address[1],1} with write_data[15:0]; word store writes all lanes.
  - The store response has data_out = the updated word.
- Load: data_out = the stored word, read on the edge entering RESP.
- Throughput:
  - At most one outstanding request; no request is accepted in WAIT or RESP.
  - Back-to-back rate is WAIT_CYCLES+2 cycles per access when resp_ready is held at 1.
- Reset mid-operation: an in-flight store that has not reached RESP is dropped and storage is unchanged. Reset asserted in RESP leaves the already-committed write in place.
- resp_ready is ignored outside RESP.

Decomposition:
- Shared package data_mem_pkg holds:
  - size-code constants SZ_NONE=3'b000, SZ_BYTE=3'b001, SZ_HALF=3'b010, SZ_WORD=3'b100;
  - the FSM state encoding IDLE/WAIT/RESP;
  - a helper that produces the 4-bit lane mask from size and address[1:0].
- One sub-module, mem_word_array: DEPTH_WORDS x 32 storage with a 4-bit lane write mask and a synchronous read port, no reset on the contents.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x10, then load 0x10, WAIT_CYCLES=2 → store response after 3 cycles with data_out=0xDEADBEEF; load returns 0xDEADBEEF, resp_err=0.
- Byte and half stores: after the word above, byte 0xAA at 0x11 and half 0x1234 at 0x12 → load 0x10 returns 0x1234AAEF.
- Errors:
  - half store at 0x13 → resp_err=1 and the word is unchanged;
  - load at 4*DEPTH_WORDS → resp_err=1, data_out=0;
  - read_enable=1 with write_enable=100 → resp_err=1;
  - write_enable=011 → resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid and data_out stay stable and req_ready=0; release → req_ready=1 on the next cycle.
- Reset mid-operation: assert rst=0 during WAIT of a store of 0x55 to 0x20 (previously 0x0) → outputs return to reset values asynchronously; a later load of 0x20 returns 0x00000000.
- Latency sweep WAIT_CYCLES=0 and 15: acceptance-to-resp_valid is exactly 1 and 16 cycles; a no-op request (write_enable=000, read_enable=0) produces no response.
